uart_msg_sender: RTL and testbench

//  Streams a host-writable byte message into a UART transmitter, one byte per
//  tx_start pulse, with a busy-based handshake. Generalises the fixed "hello"

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_msg_sender_if.sv | 33 +++
 rtl/uart_msg_sender_buffer.sv | 36 +++
 rtl/uart_msg_sender.sv | 131 +++++++++++++
 tb/tb_uart_msg_sender.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART message sender.
//   ASCII_CR / ASCII_LF : trailer symbols appended after each message pass
//   state_t             : sender FSM state encoding
//   default_byte()      : power-on contents of the message buffer ("hello")
package uart_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE,
        NEXT
    } state_t;

    // Entries 0..4 hold "hello"; every other entry starts at zero.
    function automatic logic [7:0] default_byte(input int idx);
        case (idx)
            0:       default_byte = 8'h68; // h
            1:       default_byte = 8'h65; // e
            2:       default_byte = 8'h6C; // l
            3:       default_byte = 8'h6C; // l
            4:       default_byte = 8'h6F; // o
            default: default_byte = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/uart_msg_sender_if.sv
// Host/UART-side signal bundle of uart_msg_sender.
//   master : control logic + uart_tx side (drives writes, start, tx_busy)
//   slave  : uart_msg_sender (drives tx_start, tx_data, busy, done)
interface uart_msg_sender_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int REP_W  = 4
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              start;
    logic [LW-1:0]     len;
    logic [REP_W-1:0]  repeat_n;
    logic              tx_busy;
    logic              tx_start;
    logic [DATA_W-1:0] tx_data;
    logic              busy;
    logic              done;

    modport master (
        output wr_en, wr_addr, wr_data, start, len, repeat_n, tx_busy,
        input  tx_start, tx_data, busy, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, len, repeat_n, tx_busy,
        output tx_start, tx_data, busy, done
    );
endinterface

// File: rtl/uart_msg_sender_buffer.sv
// msg_buffer: DEPTH x DATA_W message store, synchronous write, asynchronous
// read, reset-initialised to "hello" followed by zeros.
//   clk, reset : clock, async active-high reset
//   wr_en, wr_addr, wr_data : write port
//   rd_addr, rd_data        : combinational read port
module msg_buffer
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_W-1:0]        rd_data
);
    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: this store is reset on purpose -- the default message must reappear
    // after every reset, so it is built from flops rather than a RAM macro.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= DATA_W'(default_byte(i));
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_msg_sender.sv
// uart_msg_sender: streams the buffered message into uart_tx one byte per
// tx_start strobe, using tx_busy as the handshake. Each pass sends len buffer
// bytes plus an optional CR/LF trailer; repeat_n extra passes follow the first.
//   clk, reset : clock, async active-high reset
//   bus        : uart_msg_sender_if.slave (writes, start/len/repeat_n,
//                tx_busy in; tx_start, tx_data, busy, done out)
module uart_msg_sender
    import uart_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    parameter int REP_W   = 4,
    parameter int CRLF_EN = 1
) (
    input  logic            clk,
    input  logic            reset,
    uart_msg_sender_if.slave bus
);
    localparam int AW      = $clog2(DEPTH);
    localparam int LW      = AW + 1;
    localparam int TRAILER = (CRLF_EN != 0) ? 2 : 0;

    state_t            state;
    logic [LW-1:0]     idx;
    logic [LW-1:0]     len_q;
    logic [LW-1:0]     last;
    logic [REP_W-1:0]  pass;
    logic [REP_W-1:0]  rep_q;
    logic [DATA_W-1:0] buf_rd;
    logic [DATA_W-1:0] sym;
    logic              start_ok;
    logic              tx_start_q;
    logic [DATA_W-1:0] tx_data_q;
    logic              busy_q;
    logic              done_q;

    // The buffer is frozen for the whole transmission.
    msg_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_buffer (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (bus.wr_en && (state == IDLE)),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_addr (idx[AW-1:0]),
        .rd_data (buf_rd)
    );

    assign start_ok = bus.start && (bus.len != '0) && (bus.len <= LW'(DEPTH));
    assign last     = len_q + LW'(TRAILER) - LW'(1);

    // Symbol mux: buffer bytes first, then the CR/LF trailer.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        sym = buf_rd;
        if (idx == len_q) begin
            sym = DATA_W'(ASCII_CR);
        end else if (idx > len_q) begin
            sym = DATA_W'(ASCII_LF);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // branch sees the values from before this clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            pass       <= '0;
            len_q      <= '0;
            rep_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            done_q     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        len_q  <= bus.len;
                        rep_q  <= bus.repeat_n;
                        idx    <= '0;
                        pass   <= '0;
                        busy_q <= 1'b1;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    tx_data_q  <= sym;
                    tx_start_q <= 1'b1;
                    state      <= WAIT_ACK;
                end
                // tx_busy may still be low on the strobe cycle; wait for it to rise.
                WAIT_ACK: begin
                    if (bus.tx_busy) state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (!bus.tx_busy) state <= NEXT;
                end
                NEXT: begin
                    if (idx < last) begin
                        idx   <= idx + LW'(1);
                        state <= ISSUE;
                    end else if (pass < rep_q) begin
                        pass  <= pass + REP_W'(1);
                        idx   <= '0;
                        state <= ISSUE;
                    end else begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_uart_msg_sender.sv
// Directed testbench for uart_msg_sender with a simple uart_tx busy model.
module tb_uart_msg_sender;
    localparam int DATA_W   = 8;
    localparam int DEPTH    = 16;
    localparam int REP_W    = 4;
    localparam int BUSY_LEN = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_msg_sender_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .REP_W(REP_W)) bus ();

    uart_msg_sender #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .REP_W(REP_W), .CRLF_EN(1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // uart_tx model: busy for BUSY_LEN cycles, rising ack_delay cycles after the strobe.
    int          ack_delay = 0;
    int          dcnt, bcnt;
    bit          pend;
    logic [7:0]  cap_q[$];
    logic [7:0]  exp_q[$];
    int          strobes   = 0;
    int          done_cnt  = 0;
    int          busy_high = 0;
    int          overlap   = 0;
    int          done_busy = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.tx_busy <= 1'b0;
            pend        <= 1'b0;
            dcnt        <= 0;
            bcnt        <= 0;
        end else begin
            if (bus.tx_start) begin
                cap_q.push_back(bus.tx_data);
                strobes++;
                if (pend || bus.tx_busy) overlap++;
                if (ack_delay == 0) begin
                    bus.tx_busy <= 1'b1;
                    bcnt        <= BUSY_LEN;
                end else begin
                    pend <= 1'b1;
                    dcnt <= ack_delay;
                end
            end else if (pend) begin
                if (dcnt == 1) begin
                    pend        <= 1'b0;
                    bus.tx_busy <= 1'b1;
                    bcnt        <= BUSY_LEN;
                end else begin
                    dcnt <= dcnt - 1;
                end
            end else if (bus.tx_busy) begin
                if (bcnt == 1) bus.tx_busy <= 1'b0;
                else           bcnt <= bcnt - 1;
            end
            if (bus.done) done_cnt++;
            if (bus.done && bus.busy) done_busy++;
            if (bus.busy) busy_high++;
        end
    end

    task automatic clear_log();
        cap_q.delete();
        strobes   = 0;
        done_cnt  = 0;
        busy_high = 0;
        overlap   = 0;
        done_busy = 0;
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic push_msg(input string s, input int passes);
        exp_q.delete();
        for (int p = 0; p < passes; p++) begin
            push_str(s);
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endtask

    task automatic pulse_start(input logic [4:0] l, input logic [3:0] r);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.len      = l;
        bus.repeat_n = r;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic write_byte(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int i;
        for (i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done_cnt > 0) break;
        end
        if (i == 3000) check({tag, "_timeout"}, 0, 1);
        repeat (5) @(negedge clk);
    endtask

    task automatic check_bytes(input string tag);
        int n;
        check({tag, "_count"}, cap_q.size(), exp_q.size());
        n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check($sformatf("%s_byte%0d", tag, i), cap_q[i], exp_q[i]);
        check({tag, "_done"}, done_cnt, 1);
        check({tag, "_busy_end"}, bus.busy, 0);
        check({tag, "_done_busy"}, done_busy, 0);
        check({tag, "_overlap"}, overlap, 0);
    endtask

    initial begin
        int i;
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.start    = 1'b0;
        bus.len      = '0;
        bus.repeat_n = '0;
        reset        = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx_start", bus.tx_start, 0);
        check("rst_tx_data", bus.tx_data, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        reset = 1'b0;
        @(negedge clk);

        // 1: default "hello" + CR/LF, with start-to-strobe latency
        clear_log();
        push_msg("hello", 1);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.len      = 5'd5;
        bus.repeat_n = 4'd0;
        @(negedge clk);
        bus.start = 1'b0;
        check("t1_lat_cyc1_strobe", bus.tx_start, 0);
        check("t1_lat_cyc1_busy", bus.busy, 1);
        @(negedge clk);
        check("t1_lat_cyc2_strobe", bus.tx_start, 1);
        check("t1_lat_cyc2_data", bus.tx_data, 8'h68);
        wait_done("t1");
        check_bytes("t1");

        // 2: "AB" x3 passes
        write_byte(4'd0, 8'h41);
        write_byte(4'd1, 8'h42);
        clear_log();
        push_msg("AB", 3);
        pulse_start(5'd2, 4'd2);
        wait_done("t2");
        check_bytes("t2");

        // 3: start and wr_en while busy are ignored
        clear_log();
        push_msg("ABllo", 1);
        pulse_start(5'd5, 4'd0);
        repeat (30) @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'd2;
        bus.wr_data = 8'h5A;
        bus.start   = 1'b1;
        bus.len     = 5'd2;
        @(negedge clk);
        bus.wr_en = 1'b0;
        bus.start = 1'b0;
        wait_done("t3");
        check_bytes("t3");

        // 4: illegal lengths
        clear_log();
        pulse_start(5'd0, 4'd0);
        repeat (20) @(negedge clk);
        pulse_start(5'd17, 4'd0);
        repeat (20) @(negedge clk);
        check("t4_strobes", strobes, 0);
        check("t4_done", done_cnt, 0);
        check("t4_busy", busy_high, 0);

        // 5: late tx_busy acknowledge
        clear_log();
        ack_delay = 3;
        push_msg("A", 1);
        pulse_start(5'd1, 4'd0);
        wait_done("t5");
        check_bytes("t5");
        ack_delay = 0;

        // 6: reset during byte 3, then default message again
        clear_log();
        pulse_start(5'd5, 4'd0);
        for (i = 0; i < 500; i++) begin
            @(negedge clk);
            if (strobes >= 3) break;
        end
        check("t6_reach_byte3", (strobes >= 3), 1);
        reset = 1'b1;
        #1;
        check("t6_rst_tx_start", bus.tx_start, 0);
        check("t6_rst_tx_data", bus.tx_data, 0);
        check("t6_rst_busy", bus.busy, 0);
        check("t6_rst_done", bus.done, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        clear_log();
        push_msg("hello", 1);
        pulse_start(5'd5, 4'd0);
        wait_done("t6");
        check_bytes("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
